cla_multicycle_add_ctrl: RTL and testbench
==========================================

Name: cla_multicycle_add_ctrl

Overview:
Sequencer that performs a WIDTH-bit add or subtract by stepping operands through one shared SLICE-bit carry-lookahead slice adder, one slice per clock.
- Carries ripple between cycles through a carry register.
- Used in the register-bank datapath where a full-width CLA is too costly.
- Handshake is start/busy/done. The result and flags are held stable until the next accepted start.

Parameters:
WIDTH, 32, operand/result width; must be an integer multiple of SLICE
SLICE, 8, width of the slice adder used per cycle
NSLICE, WIDTH/SLICE, derived localparam: number of RUN cycles (4 at defaults)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
start  input  1  request; sampled only in IDLE
op_sub  input  1  0 = a+b, 1 = a-b; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse: result/cout/ovf valid
result  output  WIDTH  sum/difference register
cout  output  1  carry out of MSB (sub: 1 = no borrow)
ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset (asynchronous, any state, including mid-RUN):
  - state=IDLE, slice counter=0, carry reg=0.
  - result=0, cout=0, ovf=0, busy=0, done=0.
  - Any in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge latches a into opA_r and (op_sub ? ~b : b) into opB_r.
  - Carry reg := op_sub. Counter := 0. Next state RUN. busy rises after that edge.
  - start=0 holds IDLE.
- RUN, each edge:
  - Slice k = counter. The adder gets opA_r[k*SLICE +: SLICE], opB_r[same], cin = carry reg.
  - Slice sum is written to result[k*SLICE +: SLICE]. Carry reg := slice cout.
  - counter+1. Other result slices are untouched during RUN.
  - On the edge where counter == NSLICE-1:
    - cout := slice cout.
    - ovf := (opA_r[MSB] == opB_r[MSB]) && (slice sum MSB != opA_r[MSB]).
    - Next state DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then unconditionally IDLE.
- Latency: done is high in cycle NSLICE after the start-sampling edge (4 at defaults). Back-to-back throughput is one operation per NSLICE+2 cycles.
- start in RUN or DONE is ignored; it is not queued. a, b and op_sub may change freely after being accepted.
- result, cout and ovf hold their values after DONE until the next accepted start begins overwriting them. Slice 0 changes on the first RUN edge.
- Width rules: all arithmetic is modulo 2^WIDTH. The counter is ceil(log2(NSLICE)) bits wide, minimum 1.

Decomposition:
- Shared package holds:
  - State encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default WIDTH/SLICE constants.
- One natural sub-module: the team's SLICE-bit CLA-with-lookahead-carry-unit adder (a, b, cin -> sum, cout), instantiated once as the slice datapath.
- FSM, counter, operand registers and flag logic stay in this module.

Test Plan:
- Add 0x000000FF + 0x00000001, op_sub=0 -> done 4 cycles after start edge; result=0x00000100, cout=0, ovf=0; busy high for 5 cycles.
- Add 0xFFFFFFFF + 0x00000001 -> result=0x00000000, cout=1, ovf=0 (full carry ripple across all 4 slices).
- Add 0x7FFFFFFF + 0x00000001 -> result=0x80000000, cout=0, ovf=1.
- Sub 0x00000005 - 0x00000007 -> result=0xFFFFFFFE, cout=0 (borrow), ovf=0; then sub 0x80000000 - 0x00000001 -> result=0x7FFFFFFF, cout=1, ovf=1.
- Assert start every cycle while busy with different a/b -> only the first operation is performed; next start accepted only once back in IDLE; results match the first operands.
- Assert rst after the 2nd RUN edge -> all outputs 0 immediately (asynchronously); no done pulse; a fresh start afterwards completes correctly.

Source files
------------

// File: rtl/cla_multicycle_add_ctrl_pkg.sv
// Shared constants for the multicycle slice-sequenced adder.
// State encoding and default datapath geometry.
package cla_multicycle_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 8;

endpackage

// File: rtl/cla_multicycle_add_ctrl_cla.sv
// W-bit carry-lookahead slice adder.
// Each carry is formed from generate/propagate terms of the slice.
module cla_multicycle_add_ctrl_cla #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] p;
  logic [W-1:0] g;
  logic [W:0]   c;
  logic         t;

  assign p = a ^ b;
  assign g = a & b;

  // Every carry is evaluated independently from cin and the p/g terms.
  always_comb begin
    c    = '0;
    t    = 1'b0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      t = cin;
      for (int j = 0; j <= i; j++) begin
        t = g[j] | (p[j] & t);
      end
      c[i+1] = t;
    end
  end

  assign sum  = p ^ c[W-1:0];
  assign cout = c[W];

endmodule

// File: rtl/cla_multicycle_add_ctrl.sv
// Add/subtract sequencer stepping WIDTH-bit operands through
// one shared SLICE-bit lookahead adder, one slice per clock.
module cla_multicycle_add_ctrl
  import cla_multicycle_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef logic [NSLICE-1:0][SLICE-1:0] word_t;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt;
  logic            carry;
  word_t           opa;
  word_t           opb;
  word_t           res;
  logic [SLICE-1:0] ssum;
  logic            scout;
  logic            last;
  logic            accept;

  assign last   = (cnt == CW'(NSLICE - 1));
  assign accept = (state == IDLE) && start;

  cla_multicycle_add_ctrl_cla #(
    .W (SLICE)
  ) u_slice (
    .a    (opa[cnt]),
    .b    (opb[cnt]),
    .cin  (carry),
    .sum  (ssum),
    .cout (scout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      IDLE:    busy = 1'b0;
      RUN:     busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // Subtraction is a + ~b + 1, the +1 entering as the initial carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      carry <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      opa   <= a;
      opb   <= op_sub ? ~b : b;
      carry <= op_sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      res[cnt] <= ssum;
      carry    <= scout;
      cnt      <= cnt + CW'(1);
      if (last) begin
        cout <= scout;
        ovf  <= (opa[NSLICE-1][SLICE-1] == opb[NSLICE-1][SLICE-1])
             && (ssum[SLICE-1] != opa[NSLICE-1][SLICE-1]);
      end
    end
  end

  assign result = res;

endmodule

// File: tb/tb_cla_multicycle_add_ctrl.sv
// Scoreboard bench for the multicycle slice adder.
// Expected results come from a full-width arithmetic model.
module tb_cla_multicycle_add_ctrl;

  localparam int W  = 32;
  localparam int NS = 4;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op_sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  cla_multicycle_add_ctrl #(
    .WIDTH (W),
    .SLICE (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_sub (op_sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input logic s);
    exp_t e;
    logic [W:0] full;
    if (s) full = {1'b0, x} + {1'b0, ~y} + 33'd1;
    else   full = {1'b0, x} + {1'b0, y};
    e.r = full[W-1:0];
    e.c = full[W];
    if (s) e.v = (x[W-1] != y[W-1]) && (e.r[W-1] != x[W-1]);
    else   e.v = (x[W-1] == y[W-1]) && (e.r[W-1] != x[W-1]);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", 64'(result), 64'(e.r));
        check("cout", 64'(cout), 64'(e.c));
        check("ovf", 64'(ovf), 64'(e.v));
      end
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic ts, input bit storm);
    int lat;
    int nb;
    exp_t e;
    @(negedge clk);
    a = ta;
    b = tb;
    op_sub = ts;
    start = 1'b1;
    e = model(ta, tb, ts);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!storm) start = 1'b0;
    lat = -1;
    nb = 0;
    for (int n = 0; n < 20 && lat < 0; n++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) lat = n;
      if (storm) begin
        a = $urandom;
        b = $urandom;
        op_sub = 1'($urandom);
      end
    end
    start = 1'b0;
    check("latency", 64'(lat), 64'(NS));
    check("busy_cycles", 64'(nb), 64'(NS + 1));
    @(negedge clk);
    check("idle_after", 64'(busy), 64'd0);
    check("hold_result", 64'(result), 64'(e.r));
  endtask

  task automatic reset_mid_run();
    int sp;
    @(negedge clk);
    a = 32'h1234_5678;
    b = 32'h1111_1111;
    op_sub = 1'b0;
    start = 1'b1;
    sb.push_back(model(a, b, op_sub));
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    void'(sb.pop_back());
    #1;
    check("rst_result", 64'(result), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    sp = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) sp++;
    end
    check("no_activity_after_rst", 64'(sp), 64'd0);
  endtask

  initial begin
    #1;
    check("init_result", 64'(result), 64'd0);
    check("init_cout", 64'(cout), 64'd0);
    check("init_ovf", 64'(ovf), 64'd0);
    check("init_busy", 64'(busy), 64'd0);
    check("init_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_start", 64'(busy), 64'd0);

    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
    run_op(32'h1357_9BDF, 32'h1357_9BDF, 1'b1, 1'b0);
    run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      run_op($urandom, $urandom, 1'($urandom), 1'b0);
    end

    reset_mid_run();
    run_op(32'hCAFE_0000, 32'h0000_BABE, 1'b0, 1'b0);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
